// File: rtl/msg_payload_unpacker_pkg.sv
// Shared definitions for the message payload unpacker: default frame geometry,
// FSM state encoding and the width helpers used to size counters and addresses.
package msg_payload_unpacker_pkg;

  localparam int DEF_PARTICLE_LEN = 8;
  localparam int DEF_MAP_LEN      = 16;
  localparam int DEF_WORD_BYTES   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PART  = 2'd1,
    ST_MAP   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Bits needed to hold value (at least 1, so a zero still gets a real port).
  function automatic int min_bit_width(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 31; i++) begin
      if ((value >> i) != 0) width = i + 1;
    end
    return width;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/msg_payload_unpacker_packer.sv
// Byte-to-word packer: shifts accepted bytes MSB-first into a word, counts bytes in
// the frame and strobes word_ready on the byte that completes each word.
module msg_payload_unpacker_packer
  import msg_payload_unpacker_pkg::*;
#(
  parameter int WORD_BYTES = DEF_WORD_BYTES,
  parameter int CNT_W      = 5,
  localparam int WORD_W    = 8 * WORD_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_ready,
  output logic [CNT_W-1:0]  byte_cnt_next
);

  localparam int LANE_W = min_bit_width(WORD_BYTES - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);

  logic [LANE_W-1:0] lane_r;
  logic [CNT_W-1:0]  byte_cnt_r;

  assign word_ready    = shift_en && (lane_r == LAST_LANE);
  assign byte_cnt_next = byte_cnt_r + CNT_W'(shift_en);

  // Byte and lane counters; clear drops any partial word of an abandoned frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_r     <= {LANE_W{1'b0}};
      byte_cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      lane_r     <= {LANE_W{1'b0}};
      byte_cnt_r <= {CNT_W{1'b0}};
    end else if (shift_en) begin
      byte_cnt_r <= byte_cnt_next;
      lane_r     <= word_ready ? {LANE_W{1'b0}} : lane_r + LANE_W'(1'b1);
    end
  end

  // Only the bytes still waiting for their word are kept; the incoming byte
  // completes the word combinationally so the top can register it directly.
  generate
    if (WORD_BYTES > 1) begin : g_shift
      logic [WORD_W-9:0] hold_r;

      // Holding register for the leading bytes of the current word.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          hold_r <= {(WORD_W-8){1'b0}};
        end else if (clear) begin
          hold_r <= {(WORD_W-8){1'b0}};
        end else if (shift_en) begin
          hold_r <= word[WORD_W-9:0];
        end
      end

      assign word = {hold_r, byte_in};
    end else begin : g_single
      assign word = byte_in;
    end
  endgenerate

endmodule

// File: rtl/msg_payload_unpacker.sv
// Payload unpacker: edge-detects incoming bytes, tracks the frame type, and writes
// packed words into the particle or map memory with done/error pulses.
module msg_payload_unpacker
  import msg_payload_unpacker_pkg::*;
#(
  parameter int PARTICLE_MESSAGE_LENGTH = DEF_PARTICLE_LEN,
  parameter int MAP_MESSAGE_LENGTH      = DEF_MAP_LEN,
  parameter int WORD_BYTES              = DEF_WORD_BYTES,
  localparam int WORD_W   = 8 * WORD_BYTES,
  localparam int P_ADDR_W = min_bit_width(PARTICLE_MESSAGE_LENGTH / WORD_BYTES - 1),
  localparam int M_ADDR_W = min_bit_width(MAP_MESSAGE_LENGTH / WORD_BYTES - 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          msg_in,
  input  logic                data_valid,
  input  logic                particle_data_flag,
  input  logic                map_data_flag,
  output logic                particle_wr_en,
  output logic [P_ADDR_W-1:0] particle_wr_addr,
  output logic [WORD_W-1:0]   particle_wr_data,
  output logic                map_wr_en,
  output logic [M_ADDR_W-1:0] map_wr_addr,
  output logic [WORD_W-1:0]   map_wr_data,
  output logic                particle_frame_done,
  output logic                map_frame_done,
  output logic                frame_error
);

  localparam int CNT_W = min_bit_width(max_int(PARTICLE_MESSAGE_LENGTH, MAP_MESSAGE_LENGTH));
  localparam int WC_W  = max_int(P_ADDR_W, M_ADDR_W);
  localparam logic [CNT_W-1:0] P_LEN = CNT_W'(PARTICLE_MESSAGE_LENGTH);
  localparam logic [CNT_W-1:0] M_LEN = CNT_W'(MAP_MESSAGE_LENGTH);

  state_t            state_r;
  logic              data_valid_r;
  logic [WC_W-1:0]   word_cnt_r;
  logic              accept_s;
  logic              active_s;
  logic              own_flag_s;
  logic              other_flag_s;
  logic [CNT_W-1:0]  frame_len_s;
  logic              shift_en_s;
  logic              frame_full_s;
  logic [WORD_W-1:0] word_s;
  logic              word_ready_s;
  logic [CNT_W-1:0]  byte_cnt_next_s;

  // Select the flags and frame length that belong to the frame in progress.
  always_comb begin
    active_s     = 1'b0;
    own_flag_s   = 1'b0;
    other_flag_s = 1'b0;
    frame_len_s  = P_LEN;
    case (state_r)
      ST_PART: begin
        active_s     = 1'b1;
        own_flag_s   = particle_data_flag;
        other_flag_s = map_data_flag;
        frame_len_s  = P_LEN;
      end
      ST_MAP: begin
        active_s     = 1'b1;
        own_flag_s   = map_data_flag;
        other_flag_s = particle_data_flag;
        frame_len_s  = M_LEN;
      end
      default: begin
        active_s     = 1'b0;
        own_flag_s   = 1'b0;
        other_flag_s = 1'b0;
        frame_len_s  = P_LEN;
      end
    endcase
  end

  assign accept_s     = data_valid & ~data_valid_r;
  assign shift_en_s   = accept_s & active_s;
  assign frame_full_s = shift_en_s && (byte_cnt_next_s == frame_len_s);

  msg_payload_unpacker_packer #(
    .WORD_BYTES (WORD_BYTES),
    .CNT_W      (CNT_W)
  ) u_packer (
    .clk           (clk),
    .reset         (reset),
    .clear         (state_r == ST_IDLE),
    .shift_en      (shift_en_s),
    .byte_in       (msg_in),
    .word          (word_s),
    .word_ready    (word_ready_s),
    .byte_cnt_next (byte_cnt_next_s)
  );

  // Previous data_valid level, so a held-high valid yields one byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_valid_r <= 1'b0;
    end else begin
      data_valid_r <= data_valid;
    end
  end

  // Frame FSM with registered write ports and status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r             <= ST_IDLE;
      word_cnt_r          <= {WC_W{1'b0}};
      particle_wr_en      <= 1'b0;
      particle_wr_addr    <= {P_ADDR_W{1'b0}};
      particle_wr_data    <= {WORD_W{1'b0}};
      map_wr_en           <= 1'b0;
      map_wr_addr         <= {M_ADDR_W{1'b0}};
      map_wr_data         <= {WORD_W{1'b0}};
      particle_frame_done <= 1'b0;
      map_frame_done      <= 1'b0;
      frame_error         <= 1'b0;
    end else begin
      particle_wr_en      <= 1'b0;
      map_wr_en           <= 1'b0;
      particle_frame_done <= 1'b0;
      map_frame_done      <= 1'b0;
      frame_error         <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          word_cnt_r <= {WC_W{1'b0}};
          if (particle_data_flag && map_data_flag) begin
            frame_error <= 1'b1;
            state_r     <= ST_DRAIN;
          end else if (particle_data_flag) begin
            state_r <= ST_PART;
          end else if (map_data_flag) begin
            state_r <= ST_MAP;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_PART, ST_MAP: begin
          if (word_ready_s) begin
            word_cnt_r <= word_cnt_r + WC_W'(1'b1);
            if (state_r == ST_PART) begin
              particle_wr_en   <= 1'b1;
              particle_wr_addr <= word_cnt_r[P_ADDR_W-1:0];
              particle_wr_data <= word_s;
            end else begin
              map_wr_en   <= 1'b1;
              map_wr_addr <= word_cnt_r[M_ADDR_W-1:0];
              map_wr_data <= word_s;
            end
          end
          // The byte is counted before any flag change, so a last byte
          // arriving with the flag drop still completes the frame.
          if (frame_full_s) begin
            if (state_r == ST_PART) begin
              particle_frame_done <= 1'b1;
            end else begin
              map_frame_done <= 1'b1;
            end
            state_r <= ST_DRAIN;
          end else if (other_flag_s) begin
            frame_error <= 1'b1;
            state_r     <= ST_DRAIN;
          end else if (!own_flag_s) begin
            frame_error <= (byte_cnt_next_s != {CNT_W{1'b0}});
            state_r     <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (!particle_data_flag && !map_data_flag) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msg_payload_unpacker.sv
// Directed self-checking bench for msg_payload_unpacker: logs every write and pulse
// on the falling edge and compares against hand-derived frame contents.
module tb_msg_payload_unpacker;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  msg_in;
  logic        data_valid;
  logic        particle_data_flag;
  logic        map_data_flag;
  logic        particle_wr_en;
  logic [1:0]  particle_wr_addr;
  logic [15:0] particle_wr_data;
  logic        map_wr_en;
  logic [2:0]  map_wr_addr;
  logic [15:0] map_wr_data;
  logic        particle_frame_done;
  logic        map_frame_done;
  logic        frame_error;

  always #5 clk = ~clk;

  msg_payload_unpacker dut (
    .clk                 (clk),
    .reset               (reset),
    .msg_in              (msg_in),
    .data_valid          (data_valid),
    .particle_data_flag  (particle_data_flag),
    .map_data_flag       (map_data_flag),
    .particle_wr_en      (particle_wr_en),
    .particle_wr_addr    (particle_wr_addr),
    .particle_wr_data    (particle_wr_data),
    .map_wr_en           (map_wr_en),
    .map_wr_addr         (map_wr_addr),
    .map_wr_data         (map_wr_data),
    .particle_frame_done (particle_frame_done),
    .map_frame_done      (map_frame_done),
    .frame_error         (frame_error)
  );

  typedef struct {
    logic        is_map;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        done;
  } wr_t;

  wr_t wr_q[$];
  int  n_pd = 0, n_md = 0, n_err = 0, n_both = 0, n_stray = 0;
  int  b_wr, b_pd, b_md, b_err, b_both, b_stray;
  int  n_checks = 0;
  int  n_fail = 0;

  // Falling-edge monitor: records every write and counts status pulses.
  always @(negedge clk) begin
    if (reset) begin
      if (particle_wr_en) wr_q.push_back('{1'b0, {1'b0, particle_wr_addr}, particle_wr_data, particle_frame_done});
      if (map_wr_en) wr_q.push_back('{1'b1, map_wr_addr, map_wr_data, map_frame_done});
      if (particle_wr_en && map_wr_en) n_both++;
      if (particle_frame_done) n_pd++;
      if (map_frame_done) n_md++;
      if (frame_error) n_err++;
      if ((particle_frame_done && !particle_wr_en) || (map_frame_done && !map_wr_en)) n_stray++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mark();
    b_wr = wr_q.size(); b_pd = n_pd; b_md = n_md;
    b_err = n_err; b_both = n_both; b_stray = n_stray;
  endtask

  // One byte: valid rises with the byte, then msg_in is scrambled while valid stays high.
  task automatic send_byte(input logic [7:0] b, input int hold);
    msg_in = b;
    data_valid = 1'b1;
    cycle();
    if (hold > 1) begin
      msg_in = 8'hEE;
      repeat (hold - 1) cycle();
    end
    data_valid = 1'b0;
    msg_in = 8'h00;
    cycle();
  endtask

  task automatic run_frame(input bit is_map, input logic [7:0] first, input int nbytes, input int hold);
    if (is_map) map_data_flag = 1'b1;
    else particle_data_flag = 1'b1;
    repeat (2) cycle();
    for (int i = 0; i < nbytes; i++) send_byte(first + 8'(i), hold);
    repeat (2) cycle();
    particle_data_flag = 1'b0;
    map_data_flag = 1'b0;
    repeat (3) cycle();
  endtask

  // Frames carry consecutive bytes, so word k is {first+2k, first+2k+1} at address k.
  task automatic check_frame(input string tag, input bit is_map, input int n_words,
                             input logic [7:0] first, input int exp_done, input int exp_err);
    int got_n;
    got_n = wr_q.size() - b_wr;
    check_eq({tag, " writes"}, got_n, n_words);
    for (int k = 0; k < n_words && k < got_n; k++) begin
      wr_t        e;
      logic [7:0] hi;
      e  = wr_q[b_wr + k];
      hi = first + 8'(2 * k);
      check_eq($sformatf("%s port[%0d]", tag, k), e.is_map, is_map);
      check_eq($sformatf("%s addr[%0d]", tag, k), e.addr, k);
      check_eq($sformatf("%s data[%0d]", tag, k), e.data, {hi, hi + 8'd1});
      check_eq($sformatf("%s done[%0d]", tag, k), e.done, (exp_done != 0) && (k == n_words - 1));
    end
    check_eq({tag, " particle_done"}, n_pd - b_pd, is_map ? 0 : exp_done);
    check_eq({tag, " map_done"}, n_md - b_md, is_map ? exp_done : 0);
    check_eq({tag, " error"}, n_err - b_err, exp_err);
    check_eq({tag, " both_wr"}, n_both - b_both, 0);
    check_eq({tag, " stray_done"}, n_stray - b_stray, 0);
  endtask

  initial begin
    reset = 1'b0;
    msg_in = 8'h00;
    data_valid = 1'b0;
    particle_data_flag = 1'b0;
    map_data_flag = 1'b0;
    repeat (3) cycle();
    check_eq("reset ctrl", {particle_wr_en, map_wr_en, particle_frame_done, map_frame_done,
                            frame_error, particle_wr_addr, map_wr_addr}, 32'd0);
    check_eq("reset data", {particle_wr_data, map_wr_data}, 32'd0);
    reset = 1'b1;
    repeat (2) cycle();

    mark(); run_frame(1'b0, 8'h01, 8, 1);  check_frame("s1", 1'b0, 4, 8'h01, 1, 0);
    mark(); run_frame(1'b1, 8'h10, 16, 1); check_frame("s2", 1'b1, 8, 8'h10, 1, 0);
    mark(); run_frame(1'b0, 8'h01, 8, 5);  check_frame("s3", 1'b0, 4, 8'h01, 1, 0);
    mark(); run_frame(1'b0, 8'h01, 3, 1);  check_frame("s4 trunc", 1'b0, 1, 8'h01, 0, 1);
    mark(); run_frame(1'b0, 8'h11, 8, 1);  check_frame("s4 next", 1'b0, 4, 8'h11, 1, 0);

    // Header aborted upstream: flag pulse with no bytes.
    mark();
    particle_data_flag = 1'b1;
    repeat (4) cycle();
    particle_data_flag = 1'b0;
    repeat (3) cycle();
    check_frame("s5 empty", 1'b0, 0, 8'h00, 0, 0);
    mark(); run_frame(1'b1, 8'h20, 16, 1); check_frame("s5 after", 1'b1, 8, 8'h20, 1, 0);

    // Reset in the middle of a map frame.
    mark();
    map_data_flag = 1'b1;
    repeat (2) cycle();
    for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i), 1);
    check_eq("s6 pre-reset writes", wr_q.size() - b_wr, 2);
    reset = 1'b0;
    #1;
    check_eq("s6 reset ctrl", {particle_wr_en, map_wr_en, particle_frame_done, map_frame_done,
                               frame_error, particle_wr_addr, map_wr_addr}, 32'd0);
    check_eq("s6 reset data", {particle_wr_data, map_wr_data}, 32'd0);
    map_data_flag = 1'b0;
    repeat (2) cycle();
    reset = 1'b1;
    cycle();
    check_eq("s6 no error", n_err - b_err, 0);
    check_eq("s6 no done", (n_md - b_md) + (n_pd - b_pd), 0);
    mark(); run_frame(1'b1, 8'h40, 16, 1); check_frame("s6 after", 1'b1, 8, 8'h40, 1, 0);

    // Both flags in IDLE: one error, bytes ignored until both flags are low.
    mark();
    particle_data_flag = 1'b1;
    map_data_flag = 1'b1;
    repeat (2) cycle();
    send_byte(8'h50, 1);
    send_byte(8'h51, 1);
    particle_data_flag = 1'b0;
    repeat (2) cycle();
    send_byte(8'h52, 1);
    send_byte(8'h53, 1);
    map_data_flag = 1'b0;
    repeat (3) cycle();
    check_frame("s6 both", 1'b0, 0, 8'h00, 0, 1);
    mark(); run_frame(1'b0, 8'h60, 8, 1); check_frame("s6 both after", 1'b0, 4, 8'h60, 1, 0);

    // Last byte arrives in the same cycle the flag drops: completion, not error.
    mark();
    particle_data_flag = 1'b1;
    repeat (2) cycle();
    for (int i = 0; i < 7; i++) send_byte(8'h70 + 8'(i), 1);
    msg_in = 8'h77;
    data_valid = 1'b1;
    particle_data_flag = 1'b0;
    cycle();
    data_valid = 1'b0;
    repeat (3) cycle();
    check_frame("s7 last+drop", 1'b0, 4, 8'h70, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
